reg_file_sb: RTL

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 84 ++++++++
 1 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with pending-write scoreboard and sweep clear.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined.
module reg_file_sb #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            we,
  input  logic [AW-1:0]   wR,
  input  logic [XLEN-1:0] wD,
  input  logic [AW-1:0]   rR1,
  input  logic [AW-1:0]   rR2,
  output logic [XLEN-1:0] rD1,
  output logic [XLEN-1:0] rD2,
  input  logic            iss_v,
  input  logic [AW-1:0]   iss_rd,
  output logic            busy1,
  output logic            busy2,
  input  logic            clr_req,
  output logic            clr_busy
);
  localparam int NREG = 2 ** AW;
  typedef enum logic {IDLE, SWEEP} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] pend_q, pend_d;
  logic            wr_ok;
  assign wr_ok    = (state_q == IDLE) && we && (wR != '0);
  assign clr_busy = (state_q == SWEEP);
  // Next state: in IDLE commit write then issue (issue wins), optionally start a sweep; in SWEEP clear one entry per cycle
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    if (state_q == IDLE) begin
      if (wr_ok) begin
        regs_d[wR] = wD;
        pend_d[wR] = 1'b0;
      end
      if (iss_v && (iss_rd != '0)) pend_d[iss_rd] = 1'b1;
      if (clr_req) begin
        state_d = SWEEP;
        idx_d   = AW'(1);
      end
    end else begin
      regs_d[idx_q] = '0;
      pend_d[idx_q] = 1'b0;
      idx_d         = (idx_q == {AW{1'b1}}) ? AW'(1) : idx_q + AW'(1);
      state_d       = (idx_q == {AW{1'b1}}) ? IDLE : SWEEP;
    end
  end
  // State registers; reset aborts any sweep and zeroes the file and scoreboard
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= AW'(1);
      pend_q  <= '0;
      regs_q  <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      regs_q  <= regs_d;
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic hit1, hit2;
  assign hit1  = wr_ok && (wR == rR1);
  assign hit2  = wr_ok && (wR == rR2);
  assign rD1   = hit1 ? wD : regs_q[rR1];
  assign rD2   = hit2 ? wD : regs_q[rR2];
  assign busy1 = pend_q[rR1] & ~hit1;
  assign busy2 = pend_q[rR2] & ~hit2;
`else
  assign rD1   = regs_q[rR1];
  assign rD2   = regs_q[rR2];
  assign busy1 = pend_q[rR1];
  assign busy2 = pend_q[rR2];
`endif
endmodule
